// File: rtl/in_unit.sv
// MIX IN-instruction input controller: UART bytes -> 6-bit MIX codes -> 30-bit
// words written one block at a time through a request/store handshake.

module UartRX (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  sh, sh_n;
  logic        valid_n;
  logic [1:0]  sync;
  logic        rx_s;

  assign rx_s = sync[1];
  assign data = sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RX_IDLE;
      cnt     <= 4'd0;
      bit_idx <= 3'd0;
      sh      <= 8'd0;
      valid   <= 1'b0;
      sync    <= 2'b11;
    end else begin
      sync    <= {sync[0], rx};
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      valid   <= valid_n;
    end
  end

  // Start bit is re-checked at mid-bit; data and stop bits are sampled mid-bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    valid_n = 1'b0;
    case (state)
      RX_IDLE: if (!rx_s) begin
        state_n = RX_START;
        cnt_n   = 4'd0;
      end
      RX_START: begin
        if (cnt == 4'(CLKS_PER_BIT/2 - 1)) begin
          cnt_n   = 4'd0;
          bit_n   = 3'd0;
          state_n = rx_s ? RX_IDLE : RX_DATA;
        end else cnt_n = cnt + 4'd1;
      end
      RX_DATA: begin
        if (cnt == 4'(CLKS_PER_BIT - 1)) begin
          cnt_n = 4'd0;
          sh_n  = {rx_s, sh[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else bit_n = bit_idx + 3'd1;
        end else cnt_n = cnt + 4'd1;
      end
      RX_STOP: begin
        if (cnt == 4'(CLKS_PER_BIT - 1)) begin
          state_n = RX_IDLE;
          valid_n = rx_s;
        end else cnt_n = cnt + 4'd1;
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

module in_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  field,
  input  logic [11:0] addressin,
  input  logic        rx,
  input  logic        store,
  output logic [11:0] addressout,
  output logic [29:0] out,
  output logic        request,
  output logic        stop,
  output logic        busy,
  output logic        overrun
);
  logic [7:0]  rx_data, ch;
  logic        rx_valid;
  logic [5:0]  dec_code, unit;
  logic        dec_char, dec_cr;
  logic [11:0] address_next;
  logic        pending, line_end, asm_full, filled, req_fresh;
  logic [3:0]  word_cnt, last;
  logic [2:0]  char_cnt;
  logic [29:0] asm_reg, shifted;
  logic        accept, have_code;

  UartRX u_rx (.clk(clk), .reset(reset), .rx(rx), .data(rx_data), .valid(rx_valid));

  always_comb begin
    ch       = rx_data;
    dec_code = 6'd0;
    dec_char = 1'b0;
    dec_cr   = 1'b0;
    if (rx_data >= 8'h61 && rx_data <= 8'h7a) ch = rx_data - 8'd32;
    if (!rx_data[7]) begin
      if (ch == 8'd13) dec_cr = 1'b1;
      else if (ch >= 8'd32 && ch != 8'd127) begin
        dec_char = 1'b1;
        if      (ch >= 8'h41 && ch <= 8'h49) dec_code = 6'(ch - 8'd64);
        else if (ch >= 8'h4a && ch <= 8'h52) dec_code = 6'(ch - 8'd63);
        else if (ch >= 8'h53 && ch <= 8'h5a) dec_code = 6'(ch - 8'd61);
        else if (ch >= 8'h30 && ch <= 8'h39) dec_code = 6'(ch - 8'd18);
        else case (ch)
          8'h2e: dec_code = 6'd40;  8'h2c: dec_code = 6'd41;
          8'h28: dec_code = 6'd42;  8'h29: dec_code = 6'd43;
          8'h2b: dec_code = 6'd44;  8'h2d: dec_code = 6'd45;
          8'h2a: dec_code = 6'd46;  8'h2f: dec_code = 6'd47;
          8'h3d: dec_code = 6'd48;  8'h24: dec_code = 6'd49;
          8'h3c: dec_code = 6'd50;  8'h3e: dec_code = 6'd51;
          8'h40: dec_code = 6'd52;  8'h3b: dec_code = 6'd53;
          8'h3a: dec_code = 6'd54;  8'h27: dec_code = 6'd55;
          default: dec_code = 6'd0;
        endcase
      end
    end
  end

  // A store in the cycle request rises is ignored (req_fresh).
  assign last      = (unit == 6'd16) ? 4'd15 : 4'd13;
  assign accept    = request & store & ~req_fresh;
  assign have_code = line_end | (rx_valid & dec_char);
  assign shifted   = {asm_reg[23:0], line_end ? 6'd0 : dec_code};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0; request <= 1'b0; stop <= 1'b0; overrun <= 1'b0;
      addressout <= 12'd0; out <= 30'd0; unit <= 6'd0; address_next <= 12'd0;
      pending <= 1'b0; line_end <= 1'b0; asm_full <= 1'b0; filled <= 1'b0;
      req_fresh <= 1'b0; word_cnt <= 4'd0; char_cnt <= 3'd0; asm_reg <= 30'd0;
    end else begin
      stop      <= 1'b0;
      req_fresh <= 1'b0;
      if (!busy) begin
        if (start) begin
          unit <= field; addressout <= addressin; overrun <= 1'b0;
          word_cnt <= 4'd0; char_cnt <= 3'd0; line_end <= 1'b0;
          asm_full <= 1'b0; filled <= 1'b0; pending <= 1'b0;
          busy <= 1'b1; stop <= 1'b1;
        end
      end else begin
        if (accept) begin
          request    <= 1'b0;
          addressout <= addressout + 12'd1;
          word_cnt   <= word_cnt + 4'd1;
          if (word_cnt == last) begin
            if (pending) begin
              stop <= 1'b1; addressout <= address_next; pending <= 1'b0;
              line_end <= 1'b0; word_cnt <= 4'd0; char_cnt <= 3'd0; filled <= 1'b0;
            end else busy <= 1'b0;
          end
        end
        // Once the last word reaches the holding register, input is discarded.
        if (!filled) begin
          if (asm_full) begin
            if (!request) begin
              out <= asm_reg; request <= 1'b1; req_fresh <= 1'b1; asm_full <= 1'b0;
              if (word_cnt == last) filled <= 1'b1;
            end
            if (rx_valid && !line_end) overrun <= 1'b1;
          end else begin
            if (have_code) begin
              asm_reg  <= shifted;
              char_cnt <= char_cnt + 3'd1;
              if (char_cnt == 3'd4) begin
                char_cnt <= 3'd0;
                if (request) asm_full <= 1'b1;
                else begin
                  out <= shifted; request <= 1'b1; req_fresh <= 1'b1;
                  if (word_cnt == last) filled <= 1'b1;
                end
              end
            end
            if (rx_valid && dec_cr) line_end <= 1'b1;
          end
        end
        if (start) begin
          pending      <= 1'b1;
          address_next <= addressin;
        end
      end
    end
  end
endmodule

// File: tb/tb_in_unit.sv
// Randomized self-checking bench for in_unit: bytes go out on the serial line and
// every handed-off word is compared against a character-table model.

module tb_in_unit;
  logic        clk = 1'b0;
  logic        reset, start, rx;
  logic        store = 1'b0;
  logic [5:0]  field;
  logic [11:0] addressin, addressout;
  logic [29:0] out;
  logic        request, stop, busy, overrun;

  always #5 clk = ~clk;

  in_unit dut (.clk(clk), .reset(reset), .start(start), .field(field),
               .addressin(addressin), .rx(rx), .store(store),
               .addressout(addressout), .out(out), .request(request),
               .stop(stop), .busy(busy), .overrun(overrun));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [41:0] got, input logic [41:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Position in this string is the MIX code; '~' marks codes with no ASCII form.
  string MIXCH = " ABCDEFGHI~JKLMNOPQR~~STUVWXYZ0123456789.,()+-*/=$<>@;:'";
  string PUNCT = ".,()+-*/=$<>@;:'";

  function automatic int mix_code(input logic [7:0] b);
    logic [7:0] up;
    up = (b >= "a" && b <= "z") ? b - 8'd32 : b;
    for (int i = 0; i < 56; i++)
      if (i != 10 && i != 20 && i != 21 && MIXCH[i] == up) return i;
    return 0;
  endfunction

  task automatic model_block(input logic [7:0] bq[$], input int nwords, output logic [29:0] wq[$]);
    int codes[$];
    bit le;
    logic [29:0] w;
    le = 0;
    wq.delete();
    foreach (bq[i]) begin
      if (bq[i][7]) continue;
      if (bq[i] == 8'd13) begin le = 1; break; end
      if (bq[i] < 8'd32 || bq[i] == 8'd127) continue;
      codes.push_back(mix_code(bq[i]));
    end
    if (le) while (codes.size() < nwords * 5) codes.push_back(0);
    for (int k = 0; k < codes.size() / 5; k++) begin
      w = '0;
      for (int j = 0; j < 5; j++) w = {w[23:0], 6'(codes[5*k+j])};
      wq.push_back(w);
    end
  endtask

  // Handshake monitor: logs each new request, holds store while auto_store.
  bit          auto_store = 1;
  logic [41:0] cap_q[$];
  int          stop_cnt = 0, req_len = 0, last_req_len = 0;
  bit          logged = 0;
  initial forever begin
    @(negedge clk);
    if (stop) stop_cnt++;
    if (request) begin
      if (!logged) begin cap_q.push_back({addressout, out}); logged = 1; req_len = 0; end
      req_len++;
      store = auto_store;
    end else begin
      if (logged) last_req_len = req_len;
      logged = 0;
      store  = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0; tick(16);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(16); end
    rx = 1'b1; tick(18);
  endtask

  task automatic send_q(input logic [7:0] bq[$]);
    foreach (bq[i]) send_byte(bq[i]);
  endtask

  task automatic do_start(input logic [5:0] u, input logic [11:0] a);
    field = u; addressin = a; start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin tick(1); n++; end
    chk({tag, "_idle"}, 42'(busy), 42'd0);
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 4))
      0: return 8'($urandom_range(65, 90)) | (($urandom_range(0, 1) != 0) ? 8'h20 : 8'h00);
      1: return 8'($urandom_range(48, 57));
      2: return PUNCT[$urandom_range(0, 15)];
      3: return 8'h80 | 8'($urandom_range(0, 127));
      default: return ($urandom_range(0, 1) != 0) ? 8'd10 : 8'($urandom_range(32, 126));
    endcase
  endfunction

  task automatic cmp_words(input string tag, input logic [29:0] wq[$], input int base,
                           input logic [11:0] addr);
    for (int i = 0; i < wq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), cap_q[base+i], {12'(addr + 12'(i)), wq[i]});
  endtask

  logic [7:0]  bq[$], bq2[$];
  logic [29:0] wq[$], wq2[$];
  int          s0, n;

  initial begin
    reset = 1'b1; start = 1'b0; rx = 1'b1; field = '0; addressin = '0;
    tick(3); reset = 1'b0; tick(1);
    chk("rst_busy", 42'(busy), 0);    chk("rst_req", 42'(request), 0);
    chk("rst_stop", 42'(stop), 0);    chk("rst_ovr", 42'(overrun), 0);
    chk("rst_addr", 42'(addressout), 0); chk("rst_out", 42'(out), 0);

    // Idle byte is discarded
    send_byte("x"); tick(10);
    chk("idle_noreq", 42'(cap_q.size()), 0);

    // Unit 19 @100: "AB12." then random bytes and CR
    cap_q.delete(); s0 = stop_cnt;
    do_start(6'd19, 12'd100); tick(1);
    chk("t1_stop", 42'(stop_cnt), 42'(s0 + 1)); chk("t1_busy", 42'(busy), 1);
    bq = '{"A", "B", "1", "2", "."};
    send_q(bq); tick(10);
    chk("t1_nwords", 42'(cap_q.size()), 1);
    chk("t1_word0", cap_q[0], {12'd100, 6'd1, 6'd2, 6'd31, 6'd32, 6'd40});
    chk("t1_reqlow", 42'(request), 0);
    chk("t1_reqlen", 42'(last_req_len), 2);
    bq2.delete();
    repeat ($urandom_range(3, 12)) bq2.push_back(rnd_byte());
    bq2.push_back(8'd13);
    send_q(bq2);
    wait_idle("t1");
    foreach (bq2[i]) bq.push_back(bq2[i]);
    model_block(bq, 14, wq);
    chk("t1_count", 42'(cap_q.size()), 42'(wq.size()));
    cmp_words("t1", wq, 0, 12'd100);

    // "HI" CR: one data word then 13 pad words
    cap_q.delete();
    do_start(6'd19, 12'd100);
    bq = '{"H", "I", 8'd13};
    send_q(bq); wait_idle("t2");
    chk("t2_count", 42'(cap_q.size()), 14);
    chk("t2_word0", cap_q[0], {12'd100, 6'd8, 6'd9, 18'd0});
    model_block(bq, 14, wq); cmp_words("t2", wq, 0, 12'd100);

    // Card reader at 4090: address wraps
    cap_q.delete();
    do_start(6'd16, 12'd4090);
    bq = '{8'd13};
    send_q(bq); wait_idle("t3");
    chk("t3_count", 42'(cap_q.size()), 16);
    chk("t3_wrap", cap_q[6], 42'd0);
    model_block(bq, 16, wq); cmp_words("t3", wq, 0, 12'd4090);

    // Second start while busy is queued until the block ends
    cap_q.delete();
    do_start(6'd19, 12'd200);
    bq = '{"q"};
    send_q(bq);
    s0 = stop_cnt;
    do_start(6'd19, 12'd500); tick(3);
    chk("t4_nostop", 42'(stop_cnt), 42'(s0));
    send_byte(8'd13); bq.push_back(8'd13);
    n = 0;
    while (stop_cnt == s0 && n < 5000) begin tick(1); n++; end
    chk("t4_stop", 42'(stop_cnt), 42'(s0 + 1));
    chk("t4_busy", 42'(busy), 1);
    bq2 = '{"Z", 8'd13};
    send_q(bq2); wait_idle("t4");
    chk("t4_count", 42'(cap_q.size()), 28);
    model_block(bq, 14, wq);  cmp_words("t4a", wq, 0, 12'd200);
    model_block(bq2, 14, wq2); cmp_words("t4b", wq2, 14, 12'd500);

    // Stall: store held low, 11 chars -> 11th dropped, overrun set
    cap_q.delete(); auto_store = 0;
    do_start(6'd19, 12'd100);
    bq.delete();
    repeat (11) bq.push_back(8'($urandom_range(65, 90)));
    send_q(bq); tick(5);
    bq2 = bq[0:9]; bq2.push_back(8'd13);
    model_block(bq2, 14, wq);
    chk("t5_req", 42'(request), 1);
    chk("t5_held", {addressout, out}, {12'd100, wq[0]});
    chk("t5_ovr", 42'(overrun), 1);
    auto_store = 1;
    tick(20);
    send_byte(8'd13); wait_idle("t5");
    chk("t5_count", 42'(cap_q.size()), 14);
    cmp_words("t5", wq, 0, 12'd100);
    do_start(6'd19, 12'd300); tick(1);
    chk("t5_ovrclr", 42'(overrun), 0);
    send_byte(8'd13); wait_idle("t5b");

    // Reset mid-block
    cap_q.delete();
    do_start(6'd19, 12'd700);
    bq = '{"A", "B", "C", "D", "E", "F", "G"};
    send_q(bq);
    chk("t6_pre", 42'(cap_q.size()), 1);
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    chk("t6_busy", 42'(busy), 0);    chk("t6_req", 42'(request), 0);
    chk("t6_stop", 42'(stop), 0);    chk("t6_ovr", 42'(overrun), 0);
    chk("t6_addr", 42'(addressout), 0); chk("t6_out", 42'(out), 0);
    send_byte("H"); tick(50);
    chk("t6_noreq", 42'(cap_q.size()), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/in_unit.md
# in_unit

Input-device controller for the MIX `IN` instruction, the receiving counterpart of the output unit. It receives ASCII bytes from a UART RX line and converts them to 6-bit MIX character codes. It packs five codes per 30-bit word and writes one block of words to memory through a request/store handshake with the CPU. Supported units are the card reader (unit 16, 16-word block) and the terminal (unit 19 or any other field value, 14-word block).

## Interface
- No parameters; the serial bit rate is fixed inside the `UartRX` sub-block.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; CPU issues `IN`.
- `field` in 6: unit number, sampled with `start`.
- `addressin` in 12: block start address, sampled with `start`.
- `rx` in 1: UART serial input; idles high.
- `store` in 1: CPU accepts the word; only meaningful while `request`=1.
- `addressout` out 12: memory address of the word in `out`.
- `out` out 30: packed word. Character 0 occupies [29:24] and character 4 occupies [5:0].
- `request` out 1: word/address valid; held until `store`.
- `stop` out 1: one-cycle pulse; the CPU may resume.
- `busy` out 1: unit is filling a block.
- `overrun` out 1: sticky; a byte was dropped while the assembler was stalled.

## Operation
- `UartRX` instance outputs `data[7:0]` and `valid`, a 1-cycle pulse per received byte.
- **Idle** (`busy`=0):
  - Received bytes are discarded.
  - `start` latches `unit`←`field` and `addressout`←`addressin`, clears `overrun`, word count, char count and line-end flag, sets `busy`, and pulses `stop`.
- **Busy with `start`**:
  - Latches `address_next`←`addressin` and sets `pending`.
  - `stop` is withheld, which blocks the CPU.
- **Decode** (bytes with bit 7 set ignored):
  - `' '`→0; A–I→1–9; J–R→11–19; S–Z→22–29; `0`–`9`→30–39.
  - `. , ( ) + - * / = $ < > @ ; : '`→40–55 in that order.
  - Lowercase letters map as uppercase.
  - CR (13) sets line-end. LF (10) and other control bytes are ignored.
  - Any other printable byte maps to 0.
- **Assembly**:
  - Each decoded code shifts into the 30-bit assembly register; the char count increments.
  - At 5 chars, the word moves to the `out` holding register, `request`=1, and the char count resets.
- **Line-end padding**:
  - While line-end is set, one code 0 is inserted per clock whenever the assembler is not stalled.
  - Padding continues until the block's last word is handed off; incoming bytes are ignored meanwhile.
- **Write handshake**:
  - `request`&`store` clears `request`, increments `addressout` by 1 (12-bit wrap), and increments the word count.
- **Stall**:
  - If a 5th char completes while `request` is still 1, the assembler holds the word.
  - Further received bytes are dropped and set `overrun`.
  - Transfer to holding happens on the cycle after `store`.
- **Block end**: occurs on the `store` of the last word (word count 15 for unit 16, 13 otherwise).
  - With `pending`: pulse `stop`, `addressout`←`address_next`, clear `pending` and line-end, reset counts, stay busy.
  - Without `pending`: `busy`←0.
- Bytes arriving after the last word is handed off but before block end are discarded.

## Timing
- Reset values: `busy`=0, `request`=0, `stop`=0, `overrun`=0, `addressout`=0, `out`=0. All internal counters, flags and `pending` are 0.
- `stop` and `busy` assert in the cycle after `start`.
- `request` rises in the cycle after the `valid` pulse carrying the 5th char, or after the 5th pad insertion.
- A `store` in the same cycle as `request` rising is not accepted. `store` is accepted on any later cycle.
- A pad-only word takes 5 clocks to assemble after the previous holding register frees.
- Simultaneous `start` and block end while busy: the block end is processed with the old `pending`. The new `start` then sets `pending` for the following block.
- `reset` mid-block aborts immediately; no further `request` occurs.

## Test plan
- Unit 19, address 100, send "AB12." with immediate `store`.
  - Expect `out` fields {1,2,31,32,40} at `addressout` 100, then `request` low until more bytes arrive.
- Unit 19, send "HI" then CR.
  - Expect word {8,9,0,0,0} at 100, then 13 all-zero words at 101–113.
  - Expect `busy` to fall after the `store` at 113, with exactly 14 requests total.
- Unit 16, address 4090, CR only.
  - Expect 16 zero words at addresses 4090–4095, then 0–9 (wrap).
- Unit 19, `start` again mid-block with address 500.
  - Expect no `stop` until the block completes, then a `stop` pulse with the next word at 500 and `busy` still 1.
- Hold `store` low, send 11 chars.
  - Expect the first word held at 100, the second word stalled, the 11th byte dropped, and `overrun`=1.
  - Expect `overrun` to clear on the next idle `start`.
- Send "x" while idle, then `reset` mid-block.
  - The idle byte produces no `request`.
  - After reset, all outputs read 0.
